acc_drain_ctrl: RTL

Read-side controller for the accumulation FIFO bank; it is the consumer of the bank's psum output rows.
On a start command it drives the per-column read enables and captures each returned psum row. It then writes the rows one per word into the global buffer (GLB) at consecutive addresses, honouring GLB back-pressure.
It signals completion to top control; the write side of the FIFO bank (systolic array psum_en) is untouched.

---
 rtl/tpu_acc_pkg.sv | 25 ++
 rtl/acc_drain_skid.sv | 74 +++++++
 rtl/acc_drain_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/tpu_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tpu_acc_pkg
// Purpose  : Shared defaults and FSM encoding for the accumulation-FIFO drain
//            path (FIFO bank read side -> global buffer writer).
// Contents : c_PE_SIZE, c_DATA_WIDTH, c_FIFO_DEPTH, c_ADDR_WIDTH defaults;
//            drain controller state encodings.
// Revision : 1.0  initial release
// ============================================================================
package tpu_acc_pkg;

    // Default geometry of the PE array / accumulation FIFO bank.
    localparam int c_PE_SIZE    = 16;
    localparam int c_DATA_WIDTH = 32;
    localparam int c_FIFO_DEPTH = 64;
    localparam int c_ADDR_WIDTH = 10;

    // Drain controller states. Two bits cover all four states.
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_DRAIN = 2'd1;
    localparam logic [1:0] c_ST_FLUSH = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

endpackage : tpu_acc_pkg
`default_nettype wire

// File: rtl/acc_drain_skid.sv
`default_nettype none
// ============================================================================
// Module   : acc_drain_skid
// Purpose  : Two-entry skid buffer between the FIFO bank read data and the
//            GLB write port. Entry 0 is always the head, so the GLB side
//            reads a fixed register and needs no read pointer.
// Ports    : clk, rst_n     clock / asynchronous active-low reset
//            push, push_data write one entry (returning FIFO row)
//            pop             remove head entry (GLB handshake)
//            occ             number of valid entries (0..2)
//            head            head entry data (stale when occ == 0)
// Revision : 1.0  initial release
// ============================================================================
module acc_drain_skid
    import tpu_acc_pkg::*;
#(
    parameter int WIDTH = c_DATA_WIDTH * c_PE_SIZE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       occ,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] r_entry0;
    logic [WIDTH-1:0] r_entry1;
    logic [1:0]       r_occ;

    // The controller guarantees push never lands on a full buffer unless a
    // pop happens in the same cycle, and pop is only ever issued when the
    // buffer is non-empty, so the cases below are exhaustive for legal use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_entry0 <= '0;
            r_entry1 <= '0;
            r_occ    <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_entry0 <= push_data;
                    end else begin
                        r_entry1 <= push_data;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_entry0 <= r_entry1;
                    r_occ    <= r_occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged: head leaves, new data joins at
                    // the tail, which is entry 0 if that was the only entry.
                    if (r_occ == 2'd2) begin
                        r_entry0 <= r_entry1;
                        r_entry1 <= push_data;
                    end else begin
                        r_entry0 <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign occ  = r_occ;
    assign head = r_entry0;

endmodule : acc_drain_skid
`default_nettype wire

// File: rtl/acc_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : acc_drain_ctrl
// Purpose  : Read-side controller of the accumulation FIFO bank. On start it
//            reads num_rows psum rows (all lanes in lockstep), buffers them
//            in a 2-entry skid buffer and writes them, one row per GLB word,
//            to consecutive GLB addresses starting at base_addr, honouring
//            GLB back-pressure. Pulses done_o after the last GLB write.
// Ports    : clk, rst_n             clock / asynchronous active-low reset
//            start_i                one-cycle drain command (IDLE only)
//            num_rows_i             rows to drain (clamped to FIFO_DEPTH)
//            base_addr_i            GLB address of the first row
//            rden_o                 per-lane FIFO read enables (identical)
//            psum_row_i             FIFO read data, valid 1 cycle after rden
//            glb_wren_o/glb_ready_i GLB write valid / ready handshake
//            glb_addr_o/glb_wdata_o GLB write address / data
//            busy_o                 drain in progress
//            done_o                 one-cycle completion pulse
// Revision : 1.0  initial release
// ============================================================================
module acc_drain_ctrl
    import tpu_acc_pkg::*;
#(
    parameter int PE_SIZE    = c_PE_SIZE,
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int FIFO_DEPTH = c_FIFO_DEPTH,
    parameter int ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic [CNT_WIDTH-1:0]          num_rows_i,
    input  logic [ADDR_WIDTH-1:0]         base_addr_i,
    output logic [PE_SIZE-1:0]            rden_o,
    input  logic [DATA_WIDTH*PE_SIZE-1:0] psum_row_i,
    output logic                          glb_wren_o,
    input  logic                          glb_ready_i,
    output logic [ADDR_WIDTH-1:0]         glb_addr_o,
    output logic [DATA_WIDTH*PE_SIZE-1:0] glb_wdata_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int                   c_ROW_W     = DATA_WIDTH * PE_SIZE;
    localparam logic [CNT_WIDTH-1:0] c_MAX_ROWS  = CNT_WIDTH'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [1:0]            r_state;
    logic [CNT_WIDTH-1:0]  r_num_rows;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [CNT_WIDTH-1:0]  r_issued;
    logic [CNT_WIDTH-1:0]  r_written;
    logic                  r_inflight;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [1:0]            w_state_next;
    logic [CNT_WIDTH-1:0]  w_num_rows_clamped;
    logic [CNT_WIDTH-1:0]  w_written_next;
    logic [1:0]            w_occ;
    logic [c_ROW_W-1:0]    w_head;
    logic                  w_wren;
    logic                  w_pop;
    logic                  w_issue;
    logic                  w_start_accept;

    assign w_start_accept     = (r_state == c_ST_IDLE) && start_i;
    assign w_num_rows_clamped = (num_rows_i > c_MAX_ROWS) ? c_MAX_ROWS : num_rows_i;

    // GLB side: head of the skid buffer is presented whenever it holds data.
    assign w_wren         = (w_occ != 2'd0);
    assign w_pop          = w_wren && glb_ready_i;
    assign w_written_next = r_written + CNT_WIDTH'(w_pop);

    // Issue a read only if the row it returns is guaranteed a slot: rows
    // already buffered plus the one still in flight, minus the one leaving
    // this cycle, must leave at least one free entry. This admits one row
    // per cycle in steady state (occ=1, inflight=1, pop=1) and can never
    // overflow the two entries.
    assign w_issue = (r_state == c_ST_DRAIN)
                  && (r_issued < r_num_rows)
                  && (({1'b0, w_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop}));

    // ------------------------------------------------------------------
    // Skid buffer: the registered FIFO read returns data the cycle after
    // rden, which is exactly when r_inflight is high.
    // ------------------------------------------------------------------
    acc_drain_skid #(
        .WIDTH (c_ROW_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (r_inflight),
        .push_data (psum_row_i),
        .pop       (w_pop),
        .occ       (w_occ),
        .head      (w_head)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start_i) begin
                    w_state_next = (w_num_rows_clamped == '0) ? c_ST_DONE : c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (r_issued == r_num_rows) begin
                    w_state_next = c_ST_FLUSH;
                end
            end
            c_ST_FLUSH: begin
                // Look at the post-handshake count so done follows the last
                // GLB write by exactly one cycle.
                if (w_written_next == r_num_rows) begin
                    w_state_next = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_state_next = c_ST_IDLE;
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, command latches and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_num_rows <= '0;
            r_base     <= '0;
            r_issued   <= '0;
            r_written  <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_inflight <= w_issue;
            if (w_start_accept) begin
                r_num_rows <= w_num_rows_clamped;
                r_base     <= base_addr_i;
                r_issued   <= '0;
                r_written  <= '0;
            end else begin
                if (w_issue) begin
                    r_issued <= r_issued + 1'b1;
                end
                if (w_pop) begin
                    r_written <= r_written + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rden_o      = {PE_SIZE{w_issue}};
    assign glb_wren_o  = w_wren;
    assign glb_wdata_o = w_head;
    // Address width arithmetic wraps naturally modulo 2^ADDR_WIDTH.
    assign glb_addr_o  = r_base + ADDR_WIDTH'(r_written);
    assign busy_o      = (r_state == c_ST_DRAIN) || (r_state == c_ST_FLUSH);
    assign done_o      = (r_state == c_ST_DONE);

endmodule : acc_drain_ctrl
`default_nettype wire
